// File: rtl/fp4mac_dot_sequencer.sv
// Dot-product sequencer for the FP4 MAC: unpacks packed E2M1 operand words,
// streams one element per cycle, drains, flushes and returns the FP4 result.
module fp4mac_dot_sequencer #(
    parameter int LEN_W     = 12,
    parameter int DRAIN_CYC = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    input  logic             i_word_valid,
    output logic             o_word_ready,
    input  logic [31:0]      i_a_word,
    input  logic [31:0]      i_b_word,
    output logic             o_mac_clear,
    output logic             o_mac_in_valid,
    output logic             o_mac_flush,
    output logic [3:0]       o_mac_a,
    output logic [3:0]       o_mac_b,
    input  logic             i_mac_fp4_valid,
    input  logic [3:0]       i_mac_fp4,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [3:0]       o_res,
    output logic             o_err
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0]    DRAIN_LAST   = DW'(DRAIN_CYC - 1);
    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] ZERO_L       = LEN_W'(0);
    localparam logic [LEN_W-1:0] ONE_L        = LEN_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_WAIT   = 3'd5,
        ST_RESULT = 3'd6
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [LEN_W-1:0] cnt_r, words_left_r;
    logic [LEN_W:0]   len_sum_s;
    logic [LEN_W-1:0] len_words_s;
    logic [2:0]       fin_lane_r, lane_r, last_r, lane_nxt_s, last_nxt_s;
    logic [31:0]      buf_a_r, buf_b_r, buf_a_nxt_s, buf_b_nxt_s;
    logic             full_r, full_nxt_s;
    logic             load_s, emit_s, last_emit_s, fetch_s, word_ready_s, feed_nxt_s;
    logic [DW-1:0]    dcnt_r;
    logic [TW-1:0]    tcnt_r;
    logic             mac_clear_r, mac_in_valid_r, mac_flush_r;
    logic [3:0]       mac_a_r, mac_b_r, res_r;
    logic             res_valid_r, err_r, busy_r;

    function automatic logic [3:0] lane_sel(input logic [31:0] w, input logic [2:0] k);
        lane_sel = w[{k, 2'b00} +: 4];
    endfunction

    assign len_sum_s   = {1'b0, i_len} + (LEN_W + 1)'(7);
    assign len_words_s = LEN_W'(len_sum_s[LEN_W:3]);

    // Next-state, word-buffer advance and operand handshake
    always_comb begin
        state_nxt_s  = state_r;
        buf_a_nxt_s  = buf_a_r;
        buf_b_nxt_s  = buf_b_r;
        lane_nxt_s   = lane_r;
        last_nxt_s   = last_r;
        full_nxt_s   = full_r;
        load_s       = 1'b0;
        emit_s       = 1'b0;
        last_emit_s  = 1'b0;
        fetch_s      = 1'b0;
        word_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = i_start;
                if (i_start) state_nxt_s = ST_CLEAR;
                else         state_nxt_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (cnt_r == ZERO_L) state_nxt_s = ST_DRAIN;
                else                 state_nxt_s = ST_STREAM;
            end
            ST_STREAM: begin
                emit_s       = full_r;
                last_emit_s  = full_r && (lane_r == last_r);
                // Refill during the last used lane so words arrive back-to-back
                word_ready_s = (words_left_r != ZERO_L) && (!full_r || last_emit_s);
                fetch_s      = word_ready_s && i_word_valid;
                if (fetch_s) begin
                    buf_a_nxt_s = i_a_word;
                    buf_b_nxt_s = i_b_word;
                    lane_nxt_s  = 3'd0;
                    full_nxt_s  = 1'b1;
                    last_nxt_s  = (words_left_r == ONE_L) ? fin_lane_r : 3'd7;
                end else if (last_emit_s) begin
                    full_nxt_s = 1'b0;
                end else if (full_r) begin
                    lane_nxt_s = lane_r + 3'd1;
                end else begin
                    full_nxt_s = 1'b0;
                end
                if (full_r && (cnt_r == ONE_L)) state_nxt_s = ST_DRAIN;
                else                            state_nxt_s = ST_STREAM;
            end
            ST_DRAIN: begin
                if (dcnt_r == DRAIN_LAST) state_nxt_s = ST_FLUSH;
                else                      state_nxt_s = ST_DRAIN;
            end
            ST_FLUSH: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (i_mac_fp4_valid || (tcnt_r == TIMEOUT_LAST)) state_nxt_s = ST_RESULT;
                else                                             state_nxt_s = ST_WAIT;
            end
            ST_RESULT: begin
                if (i_res_ready) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_RESULT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        feed_nxt_s = (state_nxt_s == ST_STREAM) && full_nxt_s;
    end

    // State, counters, word buffer and all registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= ZERO_L;
            words_left_r   <= ZERO_L;
            fin_lane_r     <= 3'd0;
            buf_a_r        <= 32'd0;
            buf_b_r        <= 32'd0;
            lane_r         <= 3'd0;
            last_r         <= 3'd0;
            full_r         <= 1'b0;
            dcnt_r         <= DW'(0);
            tcnt_r         <= TW'(0);
            mac_clear_r    <= 1'b0;
            mac_in_valid_r <= 1'b0;
            mac_flush_r    <= 1'b0;
            mac_a_r        <= 4'd0;
            mac_b_r        <= 4'd0;
            res_r          <= 4'd0;
            err_r          <= 1'b0;
            res_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            buf_a_r <= buf_a_nxt_s;
            buf_b_r <= buf_b_nxt_s;
            lane_r  <= lane_nxt_s;
            last_r  <= last_nxt_s;
            full_r  <= full_nxt_s && (state_nxt_s == ST_STREAM);
            if (load_s) begin
                cnt_r        <= i_len;
                words_left_r <= len_words_s;
                fin_lane_r   <= i_len[2:0] - 3'd1;
            end else begin
                if (emit_s && (cnt_r != ZERO_L))          cnt_r        <= cnt_r - ONE_L;
                if (fetch_s && (words_left_r != ZERO_L)) words_left_r <= words_left_r - ONE_L;
            end
            dcnt_r <= (state_r == ST_DRAIN) ? dcnt_r + DW'(1) : DW'(0);
            tcnt_r <= (state_r == ST_WAIT)  ? tcnt_r + TW'(1) : TW'(0);
            mac_clear_r    <= (state_nxt_s == ST_CLEAR);
            mac_flush_r    <= (state_nxt_s == ST_FLUSH);
            mac_in_valid_r <= feed_nxt_s;
            if (feed_nxt_s) begin
                mac_a_r <= lane_sel(buf_a_nxt_s, lane_nxt_s);
                mac_b_r <= lane_sel(buf_b_nxt_s, lane_nxt_s);
            end
            if (state_r == ST_WAIT) begin
                if (i_mac_fp4_valid) begin
                    res_r <= i_mac_fp4;
                    err_r <= 1'b0;
                end else if (tcnt_r == TIMEOUT_LAST) begin
                    res_r <= 4'd0;
                    err_r <= 1'b1;
                end
            end
            res_valid_r <= (state_nxt_s == ST_RESULT);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign o_busy         = busy_r;
    assign o_word_ready   = word_ready_s;
    assign o_mac_clear    = mac_clear_r;
    assign o_mac_in_valid = mac_in_valid_r;
    assign o_mac_flush    = mac_flush_r;
    assign o_mac_a        = mac_a_r;
    assign o_mac_b        = mac_b_r;
    assign o_res_valid    = res_valid_r;
    assign o_res          = res_r;
    assign o_err          = err_r;

endmodule
